input_rr_arbiter: RTL

//  - Round-robin arbiter sharing the switch's single input queue among PORTS_NUM+1 input ports (index PORTS_NUM = local node).
//  - Sits between the neighbour/local links and the queue write side, in place of a fixed-priority receiver.
//  - Accepts at most one flit per cycle into the queue, acks the winning port, and never overflows the queue.

---
 rtl/input_rr_arbiter.sv | 119 +++++++++++
 1 files changed

// File: rtl/input_rr_arbiter.sv
// input_rr_arbiter: round-robin arbiter that shares one input queue among
// PORTS_NUM+1 senders (index PORTS_NUM is the local node). One flit per cycle
// at most is registered towards the queue, together with a one-hot ack back to
// the winning sender. Ports acked in the previous cycle are masked so a flit
// that the sender has not yet retired is never captured twice.
//
// Optional build macro: ARB_LOCAL_PRIO_EN -- when defined, the local port
// (index PORTS_NUM) wins whenever it is eligible and the round-robin pointer is
// left untouched by local grants; neighbour ports share the remaining slots
// round-robin. When undefined, all ports take part in pure round-robin.
module input_rr_arbiter #(
  parameter int DATA_SIZE = 32,
  parameter int ADDR_SIZE = 4,
  parameter int PORTS_NUM = 4,
  parameter int STALL_W   = 16
) (
  input  logic                                              clk,
  input  logic                                              a_rst,
  input  logic [PORTS_NUM:0]                                wr_ready_in,
  input  logic [(DATA_SIZE+ADDR_SIZE+1)*(PORTS_NUM+1)-1:0]  data_i,
  input  logic                                              is_full,
  input  logic                                              is_afull,
  output logic [PORTS_NUM:0]                                r_ready_out,
  output logic                                              wr_req,
  output logic [DATA_SIZE+ADDR_SIZE:0]                      data_o,
  output logic [STALL_W-1:0]                                stall_cnt
);

  localparam int BUS_SIZE = DATA_SIZE + ADDR_SIZE + 1;
  localparam int NP       = PORTS_NUM + 1;
  localparam int PTR_W    = (NP > 1) ? $clog2(NP) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_STALL = 2'd2
  } state_t;

  state_t             r_state;
  logic [PTR_W-1:0]   r_rr_ptr;

  logic [NP-1:0]       w_elig;
  logic [NP-1:0]       w_cand;
  logic [NP-1:0]       w_ack;
  logic                w_any;
  logic                w_can_wr;
  logic [PTR_W-1:0]    w_rr_idx;
  logic [PTR_W-1:0]    w_gnt;
  logic [PTR_W-1:0]    w_ptr_nxt;
  logic [BUS_SIZE-1:0] w_data;

  // Port index base+k taken modulo the number of ports (k never exceeds NP).
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NP) s = s - NP;
    return PTR_W'(s);
  endfunction

  // The write strobe is a pure decode of the registered state.
  assign wr_req = (r_state == S_GRANT);

  // Eligibility and queue space; a write already in flight consumes the last free slot.
  always_comb begin
    w_elig   = wr_ready_in & ~r_ready_out;
    w_any    = |w_elig;
    w_can_wr = ~is_full & ~(wr_req & is_afull);
    w_cand   = w_elig;
`ifdef ARB_LOCAL_PRIO_EN
    w_cand[PORTS_NUM] = 1'b0;
`endif
  end

  // Round-robin scan: first candidate at or after the pointer (descending loop, so lowest offset wins).
  always_comb begin
    w_rr_idx = '0;
    for (int k = NP - 1; k >= 0; k--) begin
      if (w_cand[wrap_add(r_rr_ptr, k)]) w_rr_idx = wrap_add(r_rr_ptr, k);
    end
  end

  // Final winner, next pointer, ack vector and selected flit.
  always_comb begin
    w_gnt     = w_rr_idx;
    w_ptr_nxt = wrap_add(w_rr_idx, 1);
`ifdef ARB_LOCAL_PRIO_EN
    if (w_elig[PORTS_NUM]) begin
      w_gnt     = PTR_W'(PORTS_NUM);
      w_ptr_nxt = r_rr_ptr;
    end
`endif
    w_ack  = NP'(1) << w_gnt;
    w_data = data_i[int'(w_gnt)*BUS_SIZE +: BUS_SIZE];
  end

  // Arbitration FSM with registered ack, flit, pointer and saturating stall counter.
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= '0;
      r_ready_out <= '0;
      data_o      <= '0;
      stall_cnt   <= '0;
    end else if (w_any && w_can_wr) begin
      r_state     <= S_GRANT;
      r_ready_out <= w_ack;
      data_o      <= w_data;
      r_rr_ptr    <= w_ptr_nxt;
    end else if (w_any) begin
      r_state     <= S_STALL;
      r_ready_out <= '0;
      if (stall_cnt != {STALL_W{1'b1}}) stall_cnt <= stall_cnt + STALL_W'(1);
    end else begin
      r_state     <= S_IDLE;
      r_ready_out <= '0;
    end
  end

endmodule
